// File: rtl/gene_net_pkg.sv
// Shared definitions for the Boolean gene-network stepper family:
// gene count, termination status codes and controller states.
package gene_net_pkg;

   localparam int N_GENES = 8;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_FIXED   = 2'b01;
   localparam logic [1:0] ST_CYCLE   = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/gene_net_rule.sv
// Combinational network rule: a gene turns on when any of its activators
// is on and none of its repressors is on.
module gene_net_rule
   import gene_net_pkg::*;
(
   input  logic [N_GENES-1:0]         x_i,
   input  logic [N_GENES*N_GENES-1:0] act_mat_i,
   input  logic [N_GENES*N_GENES-1:0] rep_mat_i,
   output logic [N_GENES-1:0]         nxt_o
);

   for (genvar g = 0; g < N_GENES; g++) begin : g_gene
      assign nxt_o[g] = (|(x_i & act_mat_i[g*N_GENES +: N_GENES])) &
                        ~(|(x_i & rep_mat_i[g*N_GENES +: N_GENES]));
   end

endmodule

// File: rtl/gene_net_step.sv
// Gene-network stepper: loads an initial state, advances one step per clock
// and stops on a fixed point, a detector-reported cycle, or the step limit.
module gene_net_step
   import gene_net_pkg::*;
#(
   parameter int MAX_STEPS = 255,
   localparam int SW = $clog2(MAX_STEPS + 1)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [N_GENES-1:0]           init_val,
   input  logic [N_GENES*N_GENES-1:0]   act_mat,
   input  logic [N_GENES*N_GENES-1:0]   rep_mat,
   input  logic                         cyc_flag,
   output logic [N_GENES-1:0]           x,
   output logic                         init_val_chk,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   status,
   output logic [SW-1:0]                steps
);

   state_e               state_q, state_d;
   logic [N_GENES-1:0]   x_q, x_d;
   logic                 chk_q, chk_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [1:0]           status_q, status_d;
   logic [SW-1:0]        steps_q, steps_d;
   logic [N_GENES-1:0]   nxt_s;
   logic                 flag_live_s;
   logic                 at_limit_s;

   gene_net_rule u_rule (
      .x_i       (x_q),
      .act_mat_i (act_mat),
      .rep_mat_i (rep_mat),
      .nxt_o     (nxt_s)
   );

   // The detector's history is zero right after a start, so its flag is
   // only trusted once two steps have been taken.
   assign flag_live_s = cyc_flag & (32'(steps_q) >= 32'd2);
   assign at_limit_s  = (32'(steps_q) == 32'(MAX_STEPS));

   // Next-state and output decode; busy/done follow the next state so they are registered.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      chk_d    = chk_q;
      status_d = status_q;
      steps_d  = steps_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               x_d      = init_val;
               steps_d  = {SW{1'b0}};
               status_d = ST_NONE;
               chk_d    = ~chk_q;
            end else begin
               state_d  = state_q;
            end
         end
         RUN: begin
            if (nxt_s == x_q) begin
               state_d  = DONE;
               status_d = ST_FIXED;
            end else if (flag_live_s) begin
               state_d  = DONE;
               status_d = ST_CYCLE;
            end else if (at_limit_s) begin
               state_d  = DONE;
               status_d = ST_TIMEOUT;
            end else begin
               x_d      = nxt_s;
               steps_d  = steps_q + {{(SW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d  = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= {N_GENES{1'b0}};
         chk_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         status_q <= ST_NONE;
         steps_q  <= {SW{1'b0}};
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         chk_q    <= chk_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         status_q <= status_d;
         steps_q  <= steps_d;
      end
   end

   assign x            = x_q;
   assign init_val_chk = chk_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign status       = status_q;
   assign steps        = steps_q;

endmodule

// File: tb/tb_gene_net_step.sv
// Scoreboard bench for gene_net_step: expected x traces and termination
// records are queued at start time and checked by an independent monitor.
module tb_gene_net_step;
   import gene_net_pkg::*;

   localparam int MS = 20;
   localparam int SW = $clog2(MS + 1);

   typedef struct packed {
      logic [7:0] x;
      logic [1:0] st;
      logic [7:0] steps;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  init_val = 8'h00;
   logic [63:0] act_mat = 64'h0;
   logic [63:0] rep_mat = 64'h0;
   logic        cyc_flag;
   logic [7:0]  x;
   logic        init_val_chk, busy, done;
   logic [1:0]  status;
   logic [SW-1:0] steps;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc_mode = 0;
   logic exp_chk = 1'b0;
   logic done_prev = 1'b0;
   logic [7:0] h1, h2;
   logic prev_chk;
   logic [7:0] mon_x;
   res_t mon_r;
   res_t res_q[$];
   logic [7:0] trace_q[$];
   logic [63:0] diag_m, rot_m, all_m, rep0_m;

   gene_net_step #(.MAX_STEPS(MS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .init_val(init_val),
      .act_mat(act_mat), .rep_mat(rep_mat), .cyc_flag(cyc_flag),
      .x(x), .init_val_chk(init_val_chk), .busy(busy), .done(done),
      .status(status), .steps(steps)
   );

   always #5 clk = ~clk;

   // Stand-in for the downstream period-2 detector: flags x equal to x two
   // loads ago; a toggle of init_val_chk zeroes the older history slot.
   always @(posedge clk) begin
      if (!rst_n) begin
         h1 <= 8'h00; h2 <= 8'h00; prev_chk <= 1'b0;
      end else begin
         prev_chk <= init_val_chk;
         h1 <= x;
         h2 <= (init_val_chk != prev_chk) ? 8'h00 : h1;
      end
   end

   assign cyc_flag = (cyc_mode == 2) ? (x == h2) : (cyc_mode == 1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rotr(input logic [7:0] v);
      return {v[0], v[7:1]};
   endfunction

   // Monitor: compare x every busy cycle and the termination record on done rise.
   always @(negedge clk) begin
      if (busy && trace_q.size() > 0) begin
         mon_x = trace_q.pop_front();
         chk("x_trace", {24'h0, x}, {24'h0, mon_x});
      end
      if (done && !done_prev) begin
         if (res_q.size() == 0) begin
            chk("unexpected_done", res_q.size(), 1);
         end else begin
            mon_r = res_q.pop_front();
            chk("done_x", {24'h0, x}, {24'h0, mon_r.x});
            chk("done_status", {30'h0, status}, {30'h0, mon_r.st});
            chk("done_steps", 32'(steps), {24'h0, mon_r.steps});
            chk("done_busy", {31'h0, busy}, 32'h0);
            chk("trace_left", trace_q.size(), 0);
         end
      end
      done_prev = done;
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_x"}, {24'h0, x}, 32'h0);
      chk({name, "_chk"}, {31'h0, init_val_chk}, 32'h0);
      chk({name, "_busy"}, {31'h0, busy}, 32'h0);
      chk({name, "_done"}, {31'h0, done}, 32'h0);
      chk({name, "_status"}, {30'h0, status}, 32'h0);
      chk({name, "_steps"}, 32'(steps), 32'h0);
   endtask

   // Issue start (held for hold cycles) and check the load cycle.
   task automatic do_start(input logic [7:0] iv, input int hold);
      init_val = iv;
      start = 1'b1;
      @(posedge clk); #1;
      exp_chk = ~exp_chk;
      chk("load_x", {24'h0, x}, {24'h0, iv});
      chk("load_chk", {31'h0, init_val_chk}, {31'h0, exp_chk});
      chk("load_busy", {31'h0, busy}, 32'h1);
      chk("load_steps", 32'(steps), 32'h0);
      chk("load_status", {30'h0, status}, 32'h0);
      if (hold > 1) cyc(hold - 1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_reached", {31'h0, done}, 32'h1);
      chk("busy_done_excl", {31'h0, busy & done}, 32'h0);
      cyc(1);
   endtask

   task automatic chk_hold(input logic [7:0] ex, input logic [1:0] es, input int en);
      cyc(2);
      chk("hold_x", {24'h0, x}, {24'h0, ex});
      chk("hold_status", {30'h0, status}, {30'h0, es});
      chk("hold_steps", 32'(steps), 32'(en));
      chk("hold_done", {31'h0, done}, 32'h1);
   endtask

   initial begin
      diag_m = 64'h0; rot_m = 64'h0; all_m = {64{1'b1}}; rep0_m = 64'h0;
      for (int i = 0; i < 8; i++) begin
         diag_m[8*i + i] = 1'b1;
         rot_m[8*i + ((i + 1) % 8)] = 1'b1;
         rep0_m[8*i] = 1'b1;
      end

      cyc(2);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      cyc(1);

      // Self-activation: immediate fixed point.
      act_mat = diag_m; rep_mat = 64'h0; cyc_mode = 0;
      trace_q.push_back(8'hA5);
      res_q.push_back('{x: 8'hA5, st: ST_FIXED, steps: 8'd0});
      do_start(8'hA5, 1);
      wait_done(10);
      chk_hold(8'hA5, ST_FIXED, 0);

      // Repression: one step to all-off, then fixed.
      act_mat = all_m; rep_mat = rep0_m;
      trace_q.push_back(8'h01); trace_q.push_back(8'h00);
      res_q.push_back('{x: 8'h00, st: ST_FIXED, steps: 8'd1});
      do_start(8'h01, 1);
      wait_done(10);
      chk_hold(8'h00, ST_FIXED, 1);

      // Period-2 oscillation caught by the detector.
      act_mat = rot_m; rep_mat = 64'h0; cyc_mode = 2;
      trace_q.push_back(8'h55); trace_q.push_back(8'hAA); trace_q.push_back(8'h55);
      res_q.push_back('{x: 8'h55, st: ST_CYCLE, steps: 8'd2});
      do_start(8'h55, 1);
      wait_done(10);
      chk_hold(8'h55, ST_CYCLE, 2);
      chk("p2_chk_once", {31'h0, init_val_chk}, {31'h0, exp_chk});

      // Flag forced high from start: masked for steps 0 and 1.
      cyc_mode = 1;
      trace_q.push_back(8'h01); trace_q.push_back(8'h80); trace_q.push_back(8'h40);
      res_q.push_back('{x: 8'h40, st: ST_CYCLE, steps: 8'd2});
      do_start(8'h01, 1);
      wait_done(10);
      chk_hold(8'h40, ST_CYCLE, 2);

      // Timeout after MS steps, with an ignored start mid-run.
      cyc_mode = 0;
      begin
         logic [7:0] v;
         v = 8'h01;
         for (int k = 0; k <= MS; k++) begin
            trace_q.push_back(v);
            v = rotr(v);
         end
      end
      res_q.push_back('{x: 8'h10, st: ST_TIMEOUT, steps: 8'(MS)});
      do_start(8'h01, 1);
      cyc(4);
      init_val = 8'hFF; start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("midrun_chk", {31'h0, init_val_chk}, {31'h0, exp_chk});
      chk("midrun_busy", {31'h0, busy}, 32'h1);
      chk("midrun_steps", 32'(steps), 32'd5);
      wait_done(40);
      chk_hold(8'h10, ST_TIMEOUT, MS);

      // Rerun from DONE, start held into the DONE-entry cycle.
      act_mat = diag_m;
      trace_q.push_back(8'h3C);
      res_q.push_back('{x: 8'h3C, st: ST_FIXED, steps: 8'd0});
      do_start(8'h3C, 2);
      chk("coincide_chk", {31'h0, init_val_chk}, {31'h0, exp_chk});
      chk("coincide_done", {31'h0, done}, 32'h1);
      cyc(1);
      chk_hold(8'h3C, ST_FIXED, 0);

      // Reset mid-RUN.
      act_mat = rot_m;
      do_start(8'h01, 1);
      cyc(3);
      rst_n = 1'b0;
      cyc(1);
      exp_chk = 1'b0;
      chk_reset_vals("midrst");
      rst_n = 1'b1;
      cyc(2);
      chk_reset_vals("post_rst");
      chk("queues_empty", res_q.size() + trace_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gene_net_step.md
# gene_net_step

Synchronous Boolean gene-regulatory-network stepper. Loads an 8-gene initial state, advances it one network step per clock under a run-time activation/repression matrix, and drives the state word `x` directly into the downstream period-2 cycle detector. It terminates on a fixed point, on the detector's cycle flag, or on a step limit, and reports the reason and the step count.

## Interface
- `N_GENES`, 8: genes per state word; the downstream detector requires 8.
- `MAX_STEPS`, 255: step limit before timeout. Range 1..255.
- `SW`, `$clog2(MAX_STEPS+1)`: step counter width (derived localparam).

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to load `init_val` and run.
- `init_val`  in  8  initial gene state.
- `act_mat`  in  64  row i = bits [8i+7:8i], the activator set of gene i.
- `rep_mat`  in  64  row i, the repressor set of gene i.
- `cyc_flag`  in  1  cycle flag returned by the downstream detector.
- `x`  out  8  current network state, feeds the detector.
- `init_val_chk`  out  1  toggles once per accepted start; clears the detector.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `status`  out  2  00 none, 01 fixed point, 10 cycle, 11 timeout.
- `steps`  out  SW  steps taken since the last start.

## Operation
- Next-state rule for gene i: `nxt[i] = |(x & act_row_i) & ~|(x & rep_row_i)`. Purely combinational from `x` and the matrices.
- FSM states:
  - IDLE: all outputs at reset values.
  - RUN.
  - DONE: `x`, `status` and `steps` hold.
- Reset (`rst_n`=0 at a rising edge) puts the block in IDLE with `x`=0, `init_val_chk`=0, `busy`=0, `done`=0, `status`=00, `steps`=0. Reset overrides any other event, including mid-RUN.
- From IDLE or DONE, `start`=1 causes the following: `x`←`init_val`, `steps`←0, `status`←00, `init_val_chk` toggles, go to RUN.
- In RUN, `start` is ignored. Each cycle is evaluated in priority order:
  1. If `nxt == x`: go to DONE with `status`=01. `x` and `steps` are unchanged.
  2. Else if `cyc_flag`=1 and `steps` ≥ 2: go to DONE with `status`=10. `x` and `steps` are unchanged.
  3. Else if `steps == MAX_STEPS`: go to DONE with `status`=11.
  4. Else `x`←`nxt` and `steps`←`steps`+1.
- `cyc_flag` is masked while `steps` < 2. This suppresses false hits from the detector's zeroed history registers.
- A `start` that coincides with a DONE-entry cycle is ignored. It must be re-issued once `done`=1.
- Matrix inputs are sampled every RUN cycle. Changing them mid-run is legal and takes effect on the next step.

## Timing
- Start to first new `x`: one clock. `x`=`init_val` is visible the cycle after the `start` edge.
- Each RUN cycle that steps produces exactly one new `x`. `steps` always equals the number of `nxt` loads since start.
- Termination condition to `done`=1: one clock. `busy` and `done` are never high together.
- `init_val_chk` toggles on the same edge that loads `init_val`.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `gene_net_pkg`:
  - `N_GENES`.
  - Status encodings `ST_NONE`/`ST_FIXED`/`ST_CYCLE`/`ST_TIMEOUT`.
  - FSM state enum `IDLE`/`RUN`/`DONE`.
- One sub-module, `gene_net_rule`: combinational, takes `x`, `act_mat`, `rep_mat` and produces `nxt`. It is reused by any later multi-network variant.
- Counter width is derived locally from `MAX_STEPS`.

## Test plan
- Self-activation: `act_mat` = gene i activates only itself, `rep_mat`=0, `init_val`=0xA5, `start`. Required: `x`=0xA5 at cycle 1, then `done`=1 at cycle 2 with `status`=01 and `steps`=0.
- Repression: `act_mat` all ones, `rep_mat` = bit 0 set in every row, `init_val`=0x01. Required: `x`=0x01, then `x`=0x00, then DONE with `status`=01, `steps`=1 and `x`=0x00.
- Period-2 via detector: `act_mat` row i = bit (i+1)%8 (rotate right), `init_val`=0x55, `cyc_flag` driven by the real detector. Required:
  - `x` alternates 0x55/0xAA.
  - DONE with `status`=10 the cycle after the first unmasked flag, `steps`=2.
  - `init_val_chk` toggled exactly once.
- Timeout: rotation with `init_val`=0x01, `MAX_STEPS`=20, `cyc_flag` held 0. Required: DONE with `status`=11, `steps`=20, `x`=0x10.
- Early flag mask: `cyc_flag` forced 1 from start under rotation with 0x01. Required: no DONE at `steps` 0 or 1; DONE with `status`=10 at `steps`=2.
- Control corners:
  - `start` pulsed mid-RUN: ignored, and `init_val_chk` does not toggle.
  - `rst_n` low mid-RUN: all outputs return to reset values at the next edge.
  - A new `start` from DONE reruns cleanly.
